// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, 8N1 frames with
// optional even parity (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned CLK_DIV = 5208
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy,
  output logic [2:0] state_dbg
);

  // Output contract: o_valid, o_frame_err and o_parity_err are single-cycle
  // strobes with no ready/backpressure; o_data holds until the next o_valid.

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2,
                            PARITY = 3'd3, STOP = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2,
                            STOP = 3'd4} state_t;
`endif

  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        hold_q, hold_d;
  logic [7:0]  data_d;
  logic        valid_d, ferr_d;
  logic        rx_meta, rx_sync;
  logic        tick;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        perr_d;
`endif

  assign tick      = (cnt_q == 16'd0);
  assign o_busy    = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    data_d  = o_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // After a framing error the line must go high again before a new
        // start is accepted, so a held break yields a single error.
        if (rx_sync) begin
          hold_d = 1'b0;
        end else if (!hold_q) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (tick) begin
          cnt_d = FULL;
          bit_d = 3'd0;
          state_d = rx_sync ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d   = FULL;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d     = FULL;
          par_bad_d = rx_sync ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d   = FULL;
          state_d = IDLE;
          if (!rx_sync) begin
            ferr_d = 1'b1;
            hold_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      shift_q     <= 8'h00;
      bit_q       <= 3'd0;
      hold_q      <= 1'b0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_meta     <= i_rx;
      rx_sync     <= rx_meta;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (i_rst) begin
      par_bad_q    <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      o_parity_err <= perr_d;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl at CLK_DIV=16: directed scenarios plus random frames
// scored against a frame-level model of expected pulses, timing and o_data.
module tb_uart_rx_ctrl;

  localparam int unsigned CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  // Bits on the line after the start bit up to and including stop.
  localparam int unsigned NB = 9 + PAR;
  // Line fall to pulse: 2 synchroniser flops + 1 output register.
  localparam int unsigned LAT = 3 + CLK_DIV / 2 + NB * CLK_DIV;
  localparam int W = 42;  // {cycle[31:0], kind[1:0], data[7:0]}
  localparam logic [2:0] IDLE_CODE = 3'd0;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_parity_err, o_busy;
  logic [2:0] state_dbg;

  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_data = 8'h00;

  uart_rx_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .i_rst(i_rst), .i_rx(i_rx), .o_data(o_data),
    .o_valid(o_valid), .o_frame_err(o_frame_err), .o_parity_err(o_parity_err),
    .o_busy(o_busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      i_rx = 1'b1;
    end
  endtask

  // Sends one frame and queues the pulse the model predicts for it.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    logic [10:0] bits;
    logic [1:0]  k;
    int unsigned c0;
    bits = {stop_b, par_b, d, 1'b0};
    if (!stop_b) k = 2'd2;
    else if (PAR == 1 && par_b != ^d) k = 2'd3;
    else k = 2'd1;
    if (PAR == 0) bits = {1'b1, stop_b, d, 1'b0};
    for (int i = 0; i < int'(NB) + 1; i++) begin
      @(negedge clk);
      i_rx = bits[i];
      if (i == 0) begin
        c0 = cyc;
        exp_q.push_back({32'(c0 + LAT), k, d});
      end
      repeat (CLK_DIV - 1) @(negedge clk);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic monitor();
    logic pv, pf, pp;
    logic [1:0] ok;
    logic [W-1:0] e;
    pv = 1'b0; pf = 1'b0; pp = 1'b0;
    forever begin
      @(negedge clk);
      if (o_valid || o_frame_err || o_parity_err) begin
        total++;
        if ((o_valid && pv) || (o_frame_err && pf) || (o_parity_err && pp)) begin
          bad++;
          $display("FAIL pulse_width cyc=%0d got v/f/p=%b%b%b twice, required single cycle",
                   cyc, o_valid, o_frame_err, o_parity_err);
        end
        total++;
        if (o_valid && (o_frame_err || o_parity_err)) begin
          bad++;
          $display("FAIL pulse_exclusive cyc=%0d got v/f/p=%b%b%b, required valid alone",
                   cyc, o_valid, o_frame_err, o_parity_err);
        end
        ok = o_valid ? 2'd1 : (o_frame_err ? 2'd2 : 2'd3);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d kind=%0d, required none", cyc, ok);
        end else begin
          e = exp_q.pop_front();
          if (ok !== e[9:8] || cyc !== e[41:10]) begin
            bad++;
            $display("FAIL pulse_kind_time got kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                     ok, cyc, e[9:8], e[41:10]);
          end
          if (e[9:8] == 2'd1) exp_data = e[7:0];
          total++;
          if (o_data !== exp_data) begin
            bad++;
            $display("FAIL o_data cyc=%0d got %02h, required %02h", cyc, o_data, exp_data);
          end
        end
      end
      pv = o_valid; pf = o_frame_err; pp = o_parity_err;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    i_rx  = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({o_data, o_valid, o_frame_err, o_parity_err, o_busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got data=%02h v=%b f=%b p=%b busy=%b, required all 0",
               o_data, o_valid, o_frame_err, o_parity_err, o_busy);
    end
    i_rst = 1'b0;
    idle(4);
    total++;
    if (o_busy !== 1'b0 || state_dbg !== IDLE_CODE) begin
      bad++;
      $display("FAIL reset_idle got busy=%b state=%0d, required 0/%0d", o_busy, state_dbg, IDLE_CODE);
    end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle(8);
    total++;
    if (exp_q.size() != 0 || o_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_a5 got data=%02h pending=%0d, required A5/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, ^8'h3C);
    send_frame(8'hC3, 1'b1, ^8'hC3);
    idle(8);
    total++;
    if (exp_q.size() != 0 || o_data !== 8'hC3) begin
      bad++;
      $display("FAIL back_to_back got data=%02h pending=%0d, required C3/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    i_rx = 1'b0;
    repeat (4) @(negedge clk);
    i_rx = 1'b1;
    if (o_busy) busy_cnt++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
    end
    total++;
    if (busy_cnt > int'(CLK_DIV / 2) || busy_cnt == 0) begin
      bad++;
      $display("FAIL glitch_busy got %0d cycles, required 1..%0d", busy_cnt, CLK_DIV / 2);
    end
    total++;
    if (o_busy !== 1'b0 || state_dbg !== IDLE_CODE || o_data !== 8'hC3) begin
      bad++;
      $display("FAIL glitch_idle got busy=%b state=%0d data=%02h, required 0/%0d/C3",
               o_busy, state_dbg, IDLE_CODE, o_data);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    send_frame(8'h55, 1'b0, ^8'h55);
    idle(8);
    total++;
    if (exp_q.size() != 0 || o_data !== 8'hA5) begin
      bad++;
      $display("FAIL frame_err got data=%02h pending=%0d, required A5/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    i_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    i_rx = 1'b1;
    repeat (4 * CLK_DIV + CLK_DIV / 2) @(negedge clk);
    i_rst = 1'b1;
    exp_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({o_data, o_valid, o_frame_err, o_parity_err, o_busy} !== 12'h000) begin
      bad++;
      $display("FAIL mid_frame_reset got data=%02h v=%b f=%b p=%b busy=%b, required all 0",
               o_data, o_valid, o_frame_err, o_parity_err, o_busy);
    end
    i_rst = 1'b0;
    idle((NB - 4) * CLK_DIV);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle(8);
    total++;
    if (exp_q.size() != 0 || o_data !== 8'h12) begin
      bad++;
      $display("FAIL after_reset_12 got data=%02h pending=%0d, required 12/0", o_data, exp_q.size());
    end
  endtask

  task automatic test_break();
    @(negedge clk);
    i_rx = 1'b0;
    exp_q.push_back({32'(cyc + LAT), 2'd2, 8'h00});
    repeat (3 * 11 * CLK_DIV) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL break_single_err got pending=%0d busy=%b, required 0/0", exp_q.size(), o_busy);
    end
    idle(10);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(8);
    total++;
    if (exp_q.size() != 0 || o_data !== 8'h5A) begin
      bad++;
      $display("FAIL after_break got data=%02h pending=%0d, required 5A/0", o_data, exp_q.size());
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] before;
    before = o_data;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    total++;
    if (exp_q.size() != 0 || o_data !== before) begin
      bad++;
      $display("FAIL parity_bad got data=%02h pending=%0d, required %02h/0", o_data, exp_q.size(), before);
    end
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    total++;
    if (exp_q.size() != 0 || o_data !== 8'h07) begin
      bad++;
      $display("FAIL parity_good got data=%02h pending=%0d, required 07/0", o_data, exp_q.size());
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    logic       s, p;
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 5) != 0);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      send_frame(d, s, p);
      idle(s ? $urandom_range(0, 12) : $urandom_range(4, 12));
    end
    idle(20);
    total++;
    if (exp_q.size() != 0 || o_data !== exp_data) begin
      bad++;
      $display("FAIL random_end got data=%02h pending=%0d, required %02h/0", o_data, exp_q.size(), exp_data);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: CLK_DIV, default 5208, meaning clk cycles per bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_rx  input  1  RS232 serial line (pin61), idle high, asynchronous to clk.
REQ-005 o_data  output  8  last received byte, LSB first on line.
REQ-006 o_valid  output  1  one-cycle pulse, o_data newly valid.
REQ-007 o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 o_parity_err  output  1  one-cycle pulse, parity mismatch (see Configuration).
REQ-009 o_busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer, initialised high; all decoding uses the synchronized copy only.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY (only when macro defined), STOP.
REQ-012 IDLE: on synchronized line low, go to START and load the bit counter with CLK_DIV/2 - 1 (integer division).
REQ-013 START: at counter zero (mid start bit), line still low -> DATA, counter reloaded with CLK_DIV-1; line high -> IDLE (glitch rejected), no outputs pulsed.
REQ-014 DATA: sample at each counter zero, shift into a shift register LSB first; after the 8th sample go to PARITY or STOP.
REQ-015 Bit counter SHALL be 16 bits, count down, reload with CLK_DIV-1 on every zero.
REQ-016 STOP: at mid stop bit, line high -> o_data updated and o_valid pulses the next cycle; line low -> o_frame_err pulses, o_data unchanged, o_valid not asserted.
REQ-017 After STOP sample, FSM SHALL return to IDLE in the same cycle as the pulse, and accept a new start edge immediately (back-to-back frames, no idle bit required beyond the stop half-bit).
REQ-018 Latency: o_valid SHALL rise exactly 1 clk after the mid-stop sample edge.
REQ-019 o_data SHALL hold its value until the next valid frame; a framing or parity error SHALL NOT modify it.
REQ-020 o_valid, o_frame_err, o_parity_err SHALL never be high for more than one consecutive cycle and o_valid never simultaneously with either error.
REQ-021 Line held low continuously (break) SHALL produce one o_frame_err, then the FSM waits in IDLE until the line returns high before accepting a new start.

Reset
REQ-022 i_rst high at any clk edge SHALL force: state IDLE, counter 0, shift register 0x00, synchronizer flops 1, o_data 0x00, o_valid 0, o_frame_err 0, o_parity_err 0, o_busy 0.
REQ-023 Reset mid-frame SHALL discard the partial frame with no pulse output; reception resumes on the first falling edge after i_rst deasserts.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: frame is start + 8 data + 1 even-parity + stop; PARITY state samples the parity bit at mid-bit; mismatch -> at STOP, o_parity_err pulses instead of o_valid, o_data unchanged; framing error takes priority over parity error.
REQ-025 Macro UART_RX_PARITY_EN undefined: frame is start + 8 data + stop, PARITY state absent, o_parity_err tied 0.

Verification (CLK_DIV=16 in all scenarios)
REQ-026 Send 0xA5, correct stop -> o_valid pulse exactly once, o_data=0xA5, 1 clk after mid-stop sample; errors stay 0.
REQ-027 Send 0x3C then 0xC3 back-to-back with no idle gap -> two o_valid pulses, o_data 0x3C then 0xC3.
REQ-028 Low glitch of 4 clk on idle line -> FSM returns to IDLE, no pulses, o_busy high for at most 8 clk.
REQ-029 Send 0x55 with stop bit low -> o_frame_err pulse once, o_valid 0, o_data retains previous 0xA5.
REQ-030 Assert i_rst during data bit 4 of 0xFF, then send 0x12 -> no pulse for the aborted frame, o_valid with o_data=0x12.
REQ-031 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> o_parity_err pulse, o_valid 0; with parity 1 -> o_valid, o_data=0x07.
